// File: rtl/rom_rd_pkg.sv
// Shared types and default sizes for the ROM stream reader.
package rom_rd_pkg;

    localparam int ROM_BYTES      = 32768;
    localparam int DEFAULT_ADDR_W = $clog2(ROM_BYTES);
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rom_rd_fifo.sv
// Small show-ahead FIFO buffering ROM bytes (with their last tag) toward the stream sink.
module rom_rd_fifo
    import rom_rd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = DEFAULT_DATA_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head_data,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage write; a push into a full FIFO is only legal alongside a pop of the same slot.
    // NOTE: the storage array has no reset; pointers and count do, and head_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything including a same-cycle push.
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/rom_stream_reader.sv
// Reads a (start, length) run from the synchronous program ROM and returns it as a
// valid/ready byte stream with a last flag; ROM data lands one cycle after its address.
module rom_stream_reader
    import rom_rd_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int LEN_W      = DEFAULT_LEN_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              done_q, done_d;
    logic              issue;
    logic              flush;
    logic              pop;
    logic              last_issue;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_after_pop;
    logic [CNT_W:0]    credit_used;
    logic [DATA_W:0]   head_word;

    assign pop             = dout_valid & dout_ready;
    // Slots already spoken for: buffered bytes plus the one the ROM is returning, less this cycle's pop.
    assign credit_used     = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign count_after_pop = fifo_count - CNT_W'(pop);
    assign last_issue      = (rem_q == LEN_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state, issue decision and datapath updates.
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        rem_d           = rem_q;
        rom_addr_d      = rom_addr_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        done_d          = 1'b0;
        issue           = 1'b0;
        flush           = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    ptr_d = cmd_addr;
                    rem_d = cmd_len;
                    if (cmd_len == '0) done_d  = 1'b1;
                    else               state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if (rem_q != '0 && credit_used < DEPTH_LIMIT) begin
                    issue           = 1'b1;
                    rom_addr_d      = ptr_q;
                    inflight_d      = 1'b1;
                    inflight_last_d = last_issue;
                    ptr_d           = ptr_q + ADDR_W'(1);
                    rem_d           = rem_q - LEN_W'(1);
                    if (last_issue) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if (!inflight_q && count_after_pop == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers: pointer, remaining count, last issued address, in-flight tag, done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q           <= '0;
            rem_q           <= '0;
            rom_addr_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            ptr_q           <= ptr_d;
            rem_q           <= rem_d;
            rom_addr_q      <= rom_addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    // The ROM registers rom_addr itself, so the issuing address is presented in the same cycle.
    assign rom_addr  = issue ? ptr_q : rom_addr_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    rom_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  ({inflight_last_q, rom_data}),
        .pop        (pop),
        .flush      (flush),
        .head_data  (head_word),
        .head_valid (dout_valid),
        .count      (fifo_count)
    );

    assign dout_last = head_word[DATA_W];
    assign dout_data = head_word[DATA_W-1:0];

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench: random ROM image, directed command sequence, byte-queue reference model.
module tb_rom_stream_reader;

    localparam int ROM_BYTES = 32768;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        abort;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [7:0]  dout_data;
    logic        dout_last;
    logic        busy;
    logic        done;

    rom_stream_reader dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .abort      (abort),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done)
    );

    // Synchronous ROM model: registered address, combinational data.
    logic [7:0]  rom_mem [ROM_BYTES];
    logic [14:0] rom_addr_r;
    always @(posedge clk) rom_addr_r <= rom_addr;
    assign rom_data = rom_mem[rom_addr_r];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: bytes still owed, as {last, data}.
    logic [8:0] exp_q [$];
    int  pops, k_now, done_cnt, done_k, first_k, last_pop_k;
    bit  hold_valid;
    logic [8:0] hold_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command at the current negedge; returns at the negedge after acceptance (k=0).
    task automatic send_cmd(input logic [14:0] addr, input int len);
        for (int i = 0; i < len; i++)
            exp_q.push_back({1'(i == len - 1), rom_mem[15'((int'(addr) + i) % ROM_BYTES)]});
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = 16'(len);
        check("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid  = 1'b0;
        k_now      = 0;
        pops       = 0;
        done_cnt   = 0;
        done_k     = -1;
        first_k    = -1;
        last_pop_k = -1;
        hold_valid = 1'b0;
    endtask

    // Sample the stream at this negedge, choose dout_ready for the coming edge, advance one cycle.
    task automatic tick(input logic rdy);
        logic [8:0]  obs;
        logic [31:0] w;
        dout_ready = rdy;
        obs = {dout_last, dout_data};
        if (dout_valid) begin
            if (first_k < 0) first_k = k_now;
            if (hold_valid) check("stable_while_stalled", 32'(obs), 32'(hold_word));
            if (rdy) begin
                w = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
                check("stream_byte", 32'(obs), w);
                pops++;
                last_pop_k = k_now;
                hold_valid = 1'b0;
            end else begin
                hold_valid = 1'b1;
                hold_word  = obs;
            end
        end else begin
            hold_valid = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_k = k_now;
        end
        k_now++;
        @(negedge clk);
    endtask

    // Consume the stream until done or budget expiry, then check completion.
    task automatic drain(input bit random_ready, input int budget, input int exp_len);
        while (done_cnt == 0 && k_now < budget)
            tick(random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        check("done_seen", done_cnt, 1);
        check("byte_count", pops, exp_len);
        check("queue_drained", exp_q.size(), 0);
        check("done_after_last_pop", done_k, last_pop_k + 1);
        check("done_one_cycle", done, 0);
        check("idle_after_done", cmd_ready, 1);
    endtask

    initial begin
        logic [14:0] a;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        abort      = 1'b0;
        dout_ready = 1'b0;
        hold_valid = 1'b0;
        for (int i = 0; i < ROM_BYTES; i++) rom_mem[i] = 8'($urandom);

        // Reset values before any clock edge.
        #2;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_dout_last", dout_last, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic read, full rate; a command during RUN is ignored.
        send_cmd(15'h0010, 4);
        check("basic_rom_addr_first", rom_addr, 32'h10);
        check("basic_busy", busy, 1);
        check("basic_cmd_ready_run", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_addr  = 15'h5555;
        cmd_len   = 16'd7;
        tick(1'b1);
        cmd_valid = 1'b0;
        drain(1'b0, 50, 4);
        check("basic_first_valid_k", first_k, 2);
        check("basic_back_to_back", last_pop_k - first_k, 3);
        check("basic_final_rom_addr", rom_addr, 32'h13);

        // Random backpressure.
        a = 15'($urandom);
        send_cmd(a, 16);
        drain(1'b1, 400, 16);

        // Address wrap.
        send_cmd(15'h7FFE, 4);
        drain(1'b0, 50, 4);
        check("wrap_final_rom_addr", rom_addr, 32'h0001);

        // Zero length.
        send_cmd(15'h0123, 0);
        check("zero_done", done, 1);
        check("zero_valid", dout_valid, 0);
        check("zero_cmd_ready", cmd_ready, 1);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_clear", done, 0);
        check("zero_valid_after", dout_valid, 0);

        // Abort with bytes buffered, then a fresh command.
        send_cmd(15'h0400, 100);
        while (pops < 10 && k_now < 200) tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("abort_fifo_has_bytes", dout_valid, 1);
        abort      = 1'b1;
        dout_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid_low", dout_valid, 0);
        check("abort_idle", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_no_done", done, 0);
        exp_q.delete();
        hold_valid = 1'b0;
        done_cnt   = 0;
        repeat (4) tick(1'b1);
        check("abort_no_done_later", done_cnt, 0);
        send_cmd(15'h0200, 2);
        drain(1'b0, 50, 2);

        // Full-size transfer from a random address wraps and reads every byte once.
        a = 15'($urandom);
        send_cmd(a, ROM_BYTES);
        drain(1'b0, ROM_BYTES + 20, ROM_BYTES);
        check("full_final_rom_addr", rom_addr, 32'(15'(a - 15'd1)));

        // Asynchronous reset mid-RUN, between edges.
        send_cmd(15'h1234, 20);
        repeat (5) tick(1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_dout_valid", dout_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_rom_addr", rom_addr, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        hold_valid = 1'b0;
        @(negedge clk);
        a = 15'($urandom);
        send_cmd(a, 8);
        drain(1'b1, 200, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
